sdcard_testmod: RTL

Upstream sector test sequencer for the SD card base module. On a start pulse it calls card initialisation, fills the write FIFO with a 512-byte seeded pattern, writes one sector, reads the same sector back through the read FIFO, and compares every byte. It drives the base module's call/address/FIFO ports directly and reports pass/fail, mismatch count and failing stage to top-level logic or LEDs.

---
 rtl/sdcard_pkg.sv | 44 ++++
 rtl/sdcard_patgen.sv | 18 +
 rtl/sdcard_testmod.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sdcard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sdcard_pkg -- shared constants and state encoding           |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package sdcard_pkg;

  localparam int CALL_INIT = 0;
  localparam int CALL_WR   = 1;
  localparam int CALL_RD   = 2;

  localparam int         SECTOR_BYTES = 512;
  localparam logic [9:0] IDX_LAST     = 10'(SECTOR_BYTES - 1);
  localparam logic [9:0] IDX_END      = 10'(SECTOR_BYTES);

  localparam logic [2:0] STG_NONE = 3'd0;
  localparam logic [2:0] STG_INIT = 3'd1;
  localparam logic [2:0] STG_WR   = 3'd2;
  localparam logic [2:0] STG_RD   = 3'd3;
  localparam logic [2:0] STG_CMP  = 3'd4;

  localparam logic [7:0] FAILTAG_TMO = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FILL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  function automatic logic [2:0] call_stage(input state_t s);
    case (s)
      ST_INIT:  return STG_INIT;
      ST_WRITE: return STG_WR;
      ST_READ:  return STG_RD;
      default:  return STG_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdcard_patgen.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sdcard_patgen -- seeded sector test pattern byte            |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module sdcard_patgen (
  input  logic [7:0] i_seed,
  input  logic [8:0] i_idx,
  output logic [7:0] o_byte
);

  // Upper half of the sector is the inverted lower-half sequence.
  logic [7:0] w_sum;
  assign w_sum  = i_seed + i_idx[7:0];
  assign o_byte = w_sum ^ {8{i_idx[8]}};

endmodule
`default_nettype wire

// File: rtl/sdcard_testmod.sv
`default_nettype none
// +--------------------------------------------------------------+
// | sdcard_testmod -- sector write / read-back test sequencer   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module sdcard_testmod
  import sdcard_pkg::*;
#(
  parameter logic [23:0] TIMEOUT     = 24'd10_000_000,
  parameter logic [7:0]  TAG_OK_INIT = 8'h00,
  parameter logic [7:0]  TAG_OK_WR   = 8'h05,
  parameter logic [7:0]  TAG_OK_RD   = 8'h00
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iStart,
  input  logic [22:0] iSector,
  input  logic [7:0]  iSeed,
  output logic [3:0]  oCall,
  input  logic        iDone,
  output logic [22:0] oAddr,
  input  logic [7:0]  iTag,
  output logic [1:0]  oEn,
  output logic [7:0]  oData,
  input  logic [7:0]  iData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oPass,
  output logic [9:0]  oErrCnt,
  output logic [2:0]  oStage,
  output logic [7:0]  oFailTag
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_idx;
  logic [23:0] r_tmo;
  logic [22:0] r_addr;
  logic [7:0]  r_seed;
  logic [7:0]  r_exp;
  logic [7:0]  r_fail_tag;
  logic [9:0]  r_err_cnt;
  logic [2:0]  r_stage;
  logic        r_pass;

  logic [7:0]  w_fill_byte;
  logic [7:0]  w_exp_byte;
  logic [3:0]  w_call;
  logic [1:0]  w_en;
  logic        w_in_call;
  logic        w_tag_ok;
  logic        w_tmo_hit;
  logic        w_fail;
  logic        w_mis;
  logic [9:0]  w_err_nxt;

  sdcard_patgen u_pat_fill (
    .i_seed (r_seed),
    .i_idx  (r_idx[8:0]),
    .o_byte (w_fill_byte)
  );

  sdcard_patgen u_pat_exp (
    .i_seed (r_seed),
    .i_idx  (r_idx[8:0]),
    .o_byte (w_exp_byte)
  );

  assign w_tmo_hit = (r_tmo == TIMEOUT - 24'd1);
  // Index 0 of DRAIN has no pop behind it yet; index k checks the byte popped at k-1.
  assign w_mis     = (r_state == ST_DRAIN) && (r_idx != 10'd0) && (iData != r_exp);
  assign w_err_nxt = r_err_cnt + {9'd0, w_mis};

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_call      = 4'b0000;
    w_en        = 2'b00;
    w_in_call   = 1'b0;
    w_tag_ok    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iStart) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        w_call[CALL_INIT] = 1'b1;
        w_in_call         = 1'b1;
        w_tag_ok          = (iTag == TAG_OK_INIT);
        if (iDone && w_tag_ok) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        w_en[1] = 1'b1;
        if (r_idx == IDX_LAST) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_call[CALL_WR] = 1'b1;
        w_in_call       = 1'b1;
        w_tag_ok        = (iTag[4:0] == TAG_OK_WR[4:0]);
        if (iDone && w_tag_ok) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_call[CALL_RD] = 1'b1;
        w_in_call       = 1'b1;
        w_tag_ok        = (iTag == TAG_OK_RD);
        if (iDone && w_tag_ok) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_en[0] = (r_idx != IDX_END);
        if (r_idx == IDX_END) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_fail = w_in_call && (iDone ? !w_tag_ok : w_tmo_hit);
    if (w_fail) w_state_nxt = ST_FIN;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_idx      <= 10'd0;
      r_tmo      <= 24'd0;
      r_addr     <= 23'd0;
      r_seed     <= 8'd0;
      r_exp      <= 8'd0;
      r_fail_tag <= 8'd0;
      r_err_cnt  <= 10'd0;
      r_stage    <= STG_NONE;
      r_pass     <= 1'b0;
    end else begin
      r_exp <= w_exp_byte;

      if (w_state_nxt != r_state) begin
        r_idx <= 10'd0;
      end else if (r_state == ST_FILL || r_state == ST_DRAIN) begin
        r_idx <= r_idx + 10'd1;
      end

      if (w_in_call && w_state_nxt == r_state) begin
        r_tmo <= r_tmo + 24'd1;
      end else begin
        r_tmo <= 24'd0;
      end

      if (r_state == ST_IDLE && iStart) begin
        r_addr     <= iSector;
        r_seed     <= iSeed;
        r_err_cnt  <= 10'd0;
        r_stage    <= STG_NONE;
        r_fail_tag <= 8'd0;
        r_pass     <= 1'b0;
      end

      if (w_fail) begin
        r_stage    <= call_stage(r_state);
        r_fail_tag <= iDone ? iTag : FAILTAG_TMO;
      end

      // Results are final on entry to FIN so they are valid alongside oDone.
      if (r_state == ST_DRAIN) begin
        r_err_cnt <= w_err_nxt;
        if (r_idx == IDX_END) begin
          r_pass <= (w_err_nxt == 10'd0);
          if (w_err_nxt != 10'd0) r_stage <= STG_CMP;
        end
      end
    end
  end

  assign oCall    = w_call;
  assign oEn      = w_en;
  assign oData    = (r_state == ST_FILL) ? w_fill_byte : 8'h00;
  assign oAddr    = r_addr;
  assign oBusy    = (r_state != ST_IDLE);
  assign oDone    = (r_state == ST_FIN);
  assign oPass    = r_pass;
  assign oErrCnt  = r_err_cnt;
  assign oStage   = r_stage;
  assign oFailTag = r_fail_tag;

endmodule
`default_nettype wire
